// File: rtl/vls_pkg.sv
// rtl/vls_pkg.sv - shared types and constants for the vector load streamer
package vls_pkg;

  localparam int LANES       = 8;
  localparam int PIX_SIZE    = 8;
  localparam int MEM_BYTES   = 51200;
  localparam int BLOCK_BYTES = 64;

  typedef logic [LANES*PIX_SIZE-1:0] vec_t;

  typedef struct packed {
    logic last;
    vec_t vec;
  } fifo_ent_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

endpackage

// File: rtl/vls_fifo.sv
// rtl/vls_fifo.sv - synchronous FIFO of {last, vector} with simultaneous push/pop
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module vls_fifo
  import vls_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  fifo_ent_t i_din,
  input  logic      i_pop,
  output fifo_ent_t o_dout,
  output logic      o_full,
  output logic      o_empty,
  output logic [AW:0] o_count
);

  fifo_ent_t  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // When full, a push lands in the slot being popped this same edge.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/vec_load_streamer.sv
// rtl/vec_load_streamer.sv - walks a run of 8-lane vectors and streams them out
// Optional lane-7 bounds check enabled by defining VLS_BOUNDS_CHECK_EN.
module vec_load_streamer
  import vls_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_num_vectors,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  vec_t              i_mem_rd,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output vec_t              o_out_data,
  output logic              o_out_last
);

  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam int BLOCK_STEP = BLOCK_BYTES - (LANES - 1);
  localparam int LANE7_OFF  = (LANES - 1) * LANES;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic              r_err;
  logic              r_done;
  logic              w_done_nxt;

  logic              w_accept, w_push, w_pop, w_last_issue, w_oob, w_drained;
  logic              w_full, w_empty;
  logic [FIFO_AW:0]  w_count;
  fifo_ent_t         w_din, w_head;

  assign w_accept     = (r_state == IDLE) && i_start;
  assign w_pop        = !w_empty && i_out_ready;
  assign w_last_issue = (r_issue_cnt == r_num - 1'b1);
  assign w_push       = (r_state == ISSUE) && (!w_full || w_pop) && !w_oob;
  assign w_drained    = w_empty || ((w_count == (FIFO_AW+1)'(1)) && w_pop);

`ifdef VLS_BOUNDS_CHECK_EN
  logic [ADDR_W:0] w_lane7_addr;
  assign w_lane7_addr = {1'b0, r_mem_addr} + (ADDR_W+1)'(LANE7_OFF);
  assign w_oob = (r_state == ISSUE) && (w_lane7_addr >= (ADDR_W+1)'(MEM_BYTES));
`else
  assign w_oob = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (i_num_vectors != '0) w_state_nxt = ISSUE;
          else                     w_done_nxt  = 1'b1;
        end
      end
      ISSUE: begin
        if (w_oob || (w_push && w_last_issue)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_drained) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // The eighth vector of a block jumps to the next 64-byte block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_addr  <= '0;
      r_num       <= '0;
      r_issue_cnt <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_mem_addr  <= i_base_addr;
        r_num       <= i_num_vectors;
        r_issue_cnt <= '0;
        r_err       <= 1'b0;
      end else if (w_push) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
        r_mem_addr  <= r_mem_addr + ((r_issue_cnt[2:0] == 3'd7) ?
                       ADDR_W'(BLOCK_STEP) : ADDR_W'(1));
      end
      if (w_oob) r_err <= 1'b1;
    end
  end

  assign w_din.last = w_last_issue;
  assign w_din.vec  = i_mem_rd;

  vls_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_mem_addr  = r_mem_addr;
  assign o_out_valid = !w_empty;
  assign o_out_data  = w_empty ? '0 : w_head.vec;
  assign o_out_last  = !w_empty && w_head.last;

endmodule
